tdc_multi_ch: RTL
=================

Name: tdc_multi_ch

Overview:
Parametrised multi-channel time-to-digital converter with one shared start and N_CH independent stop channels, all measured against the shared multiphase clock bus. Each start opens a measurement window. In that window each channel timestamps its first stop pulse using a coarse counter plus a fine phase code. Results leave through a FIFO with a valid/ready handshake, in channel order; channels that see no stop before timeout produce a timeout entry. The block sits between the analog front-end comparators and the histogram/readout logic.

Parameters:
PHASES, 32, number of phase taps in the phase bus
FINE_W, 5, fine code width; equals log2(PHASES)
COARSE_W, 8, coarse counter width
N_CH, 4, number of stop channels; CH_W = max(1, log2(N_CH))
TIMEOUT, 255, coarse count that closes the window; must be ≤ 2^COARSE_W-1
START_LAT, 1, coarse offset subtracted to cancel start-path latency
FIFO_DEPTH, 8, output FIFO entries; power of 2

Ports:
sync_clk  in  1  measurement clock, same frequency and phase as phase[0]
rst  in  1  reset
phase  in  PHASES  multiphase clock taps
start  in  1  start pulse, asynchronous
stop  in  N_CH  stop pulses, asynchronous, one per channel
tof_ready  in  1  consumer ready
tof_valid  out  1  FIFO head is valid
tof_data  out  COARSE_W+FINE_W  time of flight
tof_ch  out  CH_W  channel index of the head entry
tof_timeout  out  1  head entry is a timeout (tof_data = 0)
busy  out  1  state != IDLE
start_missed  out  1  sticky: a start arrived while not IDLE

Behaviour:
- Reset: rst is asynchronous, active-low. It clears every flop, empties the FIFO and returns the FSM to IDLE. All outputs reset to 0. A reset mid-window discards pending results.
- Fine capture:
  - Posedge start latches phase into start_code.
  - Posedge stop[i] latches phase into stop_code[i]. It does so only while the channel is not yet hit in the current window, or in IDLE.
  - These are asynchronous-edge flops.
  - fine = popcount(code) mod PHASES.
- Start sync: start passes through a 2-flop synchroniser on posedge sync_clk. Its rising edge is the trigger.
- Stop sync, per channel:
  - stop_n samples stop[i] on negedge sync_clk.
  - stop_p samples stop[i] on posedge sync_clk.
  - vout = stop_code[i][0] ? stop_p : stop_n.
  - sync_r samples vout on negedge.
  - A hit is the rising edge of sync_r, seen on posedge sync_clk.
- Coarse counter:
  - Cleared to 0 on IDLE->ARMED.
  - In ARMED it increments by 1 each posedge and saturates at TIMEOUT (no wrap).
- FSM, in posedge sync_clk:
  - IDLE -> ARMED on the synchronised start rise. Clear the hit/pending flags.
  - In ARMED, the first hit on channel i latches coarse_i = counter and sets hit[i] and pend[i]. Later stops on channel i are ignored.
  - ARMED -> DRAIN when all hit[i] = 1, or when counter == TIMEOUT. On timeout every unhit channel sets pend[i] with its timeout flag set.
  - DRAIN -> IDLE when pend == 0 and nothing is in flight.
- Arbiter:
  - Each cycle, in ARMED or DRAIN, if the FIFO is not full, push the lowest-index pend[i] and clear it.
  - At most one push per cycle.
  - A full FIFO stalls pushes; results are never dropped.
- Entry: tof = {coarse_i, stop_fine_i} - {START_LAT, start_fine}, computed modulo 2^(COARSE_W+FINE_W). A timeout entry carries tof_data = 0 and tof_timeout = 1.
- FIFO:
  - First-word-fall-through; tof_valid = !empty.
  - Pop on tof_valid & tof_ready.
  - Head outputs are stable while tof_valid & !tof_ready.
  - A simultaneous push and pop on a full FIFO is allowed; the count is unchanged.
- Start edge cases:
  - A synchronised start rise in ARMED or DRAIN is ignored and sets start_missed.
  - A start on the same cycle as DRAIN->IDLE is ignored and flagged.
- Stops in IDLE or DRAIN produce no entry.
- Stops on several channels in the same cycle are all latched in that cycle and pushed on consecutive cycles in ascending channel order.

Test Plan:
1. Single channel, N_CH=1.
   - Stimulus: start with a code of popcount 3; stop on ch0 with popcount 7, detected at counter 10; tof_ready=1.
   - Required: one entry, tof_data = 10*32+7 - (32+3) = 292, tof_ch = 0, tof_timeout = 0, busy drops afterwards.
2. Four channels hit at counters 5, 5, 9 and 20 (same cycle for ch0 and ch1).
   - Required: four entries in order ch0, ch1, ch2, ch3 with the matching tof values; ch0 and ch1 are pushed on consecutive cycles.
3. Only ch2 hits, at counter 4; TIMEOUT = 15.
   - Required: ch2 entry, then timeout entries for ch0, ch1 and ch3 (tof_data = 0, tof_timeout = 1), pushed when the counter reaches 15.
4. Backpressure.
   - Stimulus: tof_ready = 0 with FIFO_DEPTH = 2 and 4 hits.
   - Required: tof_valid = 1, the head is held stable, busy stays high; after tof_ready = 1 all 4 entries arrive in order with none lost.
5. Second start mid-window.
   - Required: start_missed = 1 and sticky; the window and counter are unaffected.
   - Then assert rst low mid-DRAIN: all outputs go to 0, the FIFO is empty, and the next start yields a fresh window.

Source files
------------

// File: rtl/tdc_multi_ch.sv
// rtl/tdc_multi_ch.sv - multi-channel TDC: shared start, N_CH stops, coarse+fine timestamps into an output FIFO
`timescale 1ns/1ps

module tdc_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Caller only pushes when there is room, or when full and popping in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module tdc_multi_ch #(
    parameter int PHASES     = 32,
    parameter int FINE_W     = 5,
    parameter int COARSE_W   = 8,
    parameter int N_CH       = 4,
    parameter int TIMEOUT    = 255,
    parameter int START_LAT  = 1,
    parameter int FIFO_DEPTH = 8,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       sync_clk,
    input  logic                       rst,
    input  logic [PHASES-1:0]          phase,
    input  logic                       start,
    input  logic [N_CH-1:0]            stop,
    input  logic                       tof_ready,
    output logic                       tof_valid,
    output logic [COARSE_W+FINE_W-1:0] tof_data,
    output logic [CH_W-1:0]            tof_ch,
    output logic                       tof_timeout,
    output logic                       busy,
    output logic                       start_missed
);
    localparam int DW = COARSE_W + FINE_W;
    localparam int EW = 1 + CH_W + DW;
    localparam logic [COARSE_W-1:0] TMO = COARSE_W'(TIMEOUT);
    localparam logic [COARSE_W-1:0] LAT = COARSE_W'(START_LAT);

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN} state_t;

    state_t                      state;
    state_t                      state_nx;
    logic [COARSE_W-1:0]         counter;
    logic [N_CH-1:0]             hit;
    logic [N_CH-1:0]             pend;
    logic [N_CH-1:0]             tmo;
    logic [COARSE_W-1:0]         coarse_q [N_CH];
    logic [FINE_W-1:0]           start_fine_q;
    logic [PHASES-1:0]           start_code;
    logic                        start_s1;
    logic                        start_s2;
    logic                        start_s3;
    logic                        start_rise;
    logic [N_CH-1:0]             hit_rise;
    logic [N_CH-1:0][FINE_W-1:0] stop_fine;
    logic [N_CH-1:0]             hit_new;
    logic [N_CH-1:0]             to_new;
    logic [N_CH-1:0]             grant;
    logic [CH_W-1:0]             grant_idx;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;
    logic                        can_push;
    logic [DW-1:0]               tof_calc;
    logic [EW-1:0]               push_entry;
    logic [EW-1:0]               head;

    function automatic logic [FINE_W-1:0] fine_of(input logic [PHASES-1:0] code);
        logic [FINE_W:0] cnt;
        cnt = '0;
        for (int k = 0; k < PHASES; k++) cnt = cnt + {{FINE_W{1'b0}}, code[k]};
        return cnt[FINE_W-1:0];
    endfunction

    always_ff @(posedge start or negedge rst) begin
        if (!rst) start_code <= '0;
        else      start_code <= phase;
    end

    always_ff @(posedge sync_clk or negedge rst) begin
        if (!rst) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_s3 <= 1'b0;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            start_s3 <= start_s2;
        end
    end
    assign start_rise = start_s2 & ~start_s3;

    // Bit 0 of the captured code tells which half-cycle the stop landed in, so the
    // synchroniser picks whichever sampler had a full half period to settle.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [PHASES-1:0] code;
        logic              stop_n;
        logic              stop_p;
        logic              sync_r;
        logic              sync_q;

        always_ff @(posedge stop[gi] or negedge rst) begin
            if (!rst)                           code <= '0;
            else if (state == IDLE || !hit[gi]) code <= phase;
        end

        always_ff @(negedge sync_clk or negedge rst) begin
            if (!rst) begin
                stop_n <= 1'b0;
                sync_r <= 1'b0;
            end else begin
                stop_n <= stop[gi];
                sync_r <= code[0] ? stop_p : stop_n;
            end
        end

        always_ff @(posedge sync_clk or negedge rst) begin
            if (!rst) begin
                stop_p <= 1'b0;
                sync_q <= 1'b0;
            end else begin
                stop_p <= stop[gi];
                sync_q <= sync_r;
            end
        end

        assign hit_rise[gi]  = sync_r & ~sync_q;
        assign stop_fine[gi] = fine_of(code);
    end

    assign hit_new = (state == ARMED) ? (hit_rise & ~hit) : '0;
    assign to_new  = (state == ARMED && counter == TMO) ? ~(hit | hit_new) : '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_rise) state_nx = ARMED;
            ARMED:   if ((&hit) || counter == TMO) state_nx = DRAIN;
            DRAIN:   if (pend == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign fifo_pop = !fifo_empty && tof_ready;
    assign can_push = !fifo_full || fifo_pop;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (state != IDLE && can_push) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    grant     = '0;
                    grant[i]  = 1'b1;
                    grant_idx = i[CH_W-1:0];
                end
            end
        end
    end

    assign tof_calc   = {coarse_q[grant_idx], stop_fine[grant_idx]} - {LAT, start_fine_q};
    assign push_entry = {tmo[grant_idx], grant_idx, tmo[grant_idx] ? {DW{1'b0}} : tof_calc};

    always_ff @(posedge sync_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            counter      <= '0;
            hit          <= '0;
            pend         <= '0;
            tmo          <= '0;
            start_fine_q <= '0;
            start_missed <= 1'b0;
            for (int i = 0; i < N_CH; i++) coarse_q[i] <= '0;
        end else begin
            state <= state_nx;
            if (start_rise && state != IDLE) start_missed <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        counter      <= '0;
                        hit          <= '0;
                        pend         <= '0;
                        tmo          <= '0;
                        start_fine_q <= fine_of(start_code);
                    end
                end
                ARMED: begin
                    if (counter != TMO) counter <= counter + 1'b1;
                    hit  <= hit | hit_new;
                    pend <= (pend & ~grant) | hit_new | to_new;
                    tmo  <= tmo | to_new;
                end
                default: pend <= pend & ~grant;
            endcase
            for (int i = 0; i < N_CH; i++) begin
                if (hit_new[i]) coarse_q[i] <= counter;
            end
        end
    end

    tdc_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sync_clk),
        .rst       (rst),
        .push      (|grant),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    assign tof_valid                         = !fifo_empty;
    assign {tof_timeout, tof_ch, tof_data}   = fifo_empty ? {EW{1'b0}} : head;
    assign busy                              = (state != IDLE);
endmodule
